// File: rtl/hc05_spi_port.sv
// hc05_spi_port: cycle-level model of the 68HC05 SPI peripheral as seen by
// the slave MCU core. The CPU programs SPCR/SPSR/SPDR over a small register
// bus. Each 8-bit transfer is timed by a down-counter, then presented to the
// parallel SPI link as a one-cycle byte strobe that also captures the
// responder's byte. SPIF, WCOL and MODF are modelled, including the
// externally forced mode fault.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   cpu_addr            0=SPCR 1=SPSR 2=SPDR 3=reserved (reads 0xFF)
//   cpu_wdata, cpu_we   register write data / one-cycle write strobe
//   cpu_re              one-cycle read strobe (drives the flag-clear sequences)
//   cpu_rdata           read data, combinational from cpu_addr
//   irq                 registered level interrupt, SPIE & (SPIF | MODF)
//   spi_write, spi_mosi parallel link byte strobe and byte sent
//   spi_miso            responder byte, sampled in the spi_write cycle
//   mode_fault_in       forced mode fault pulse
module hc05_spi_port #(
    parameter int unsigned BASE_DIV = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_we,
    input  logic       cpu_re,
    output logic [7:0] cpu_rdata,
    output logic       irq,
    output logic       spi_write,
    output logic [7:0] spi_mosi,
    input  logic [7:0] spi_miso,
    input  logic       mode_fault_in
);

    // Wide enough for the longest transfer, 8 * 32 * BASE_DIV - 1.
    localparam int unsigned CW = $clog2(256 * BASE_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] load_value;

    logic          spie, spe, mstr, cpol, cpha;
    logic [1:0]    spr;
    logic          spif, wcol, modf;
    logic          arm_flag_clr, arm_modf_clr;
    logic [7:0]    rx_buf, tx_latch;
    logic          strobe_q;

    logic          wr_spcr, wr_spdr, rd_spsr, rd_spdr, fault;

    assign wr_spcr = cpu_we && (cpu_addr == 2'd0);
    assign wr_spdr = cpu_we && (cpu_addr == 2'd2);
    assign rd_spsr = cpu_re && (cpu_addr == 2'd1);
    assign rd_spdr = cpu_re && (cpu_addr == 2'd2);

    // A forced fault only counts while the port is an enabled master.
    assign fault = mode_fault_in && spe && mstr;

    // The strobe is registered, but a fault arriving in the DONE cycle must
    // still suppress it, so the fault gates the registered strobe here.
    assign spi_write = strobe_q && !fault;

    // Counter preload: 8 bit times minus one, bit time = BASE_DIV * {2,4,16,32}.
    always_comb begin
        unique case (spr)
            2'd0:    load_value = CW'(16  * BASE_DIV - 1);
            2'd1:    load_value = CW'(32  * BASE_DIV - 1);
            2'd2:    load_value = CW'(128 * BASE_DIV - 1);
            default: load_value = CW'(256 * BASE_DIV - 1);
        endcase
    end

    always_comb begin
        unique case (cpu_addr)
            2'd0:    cpu_rdata = {spie, spe, 1'b0, mstr, cpol, cpha, spr};
            2'd1:    cpu_rdata = {spif, wcol, 1'b0, modf, 4'b0000};
            2'd2:    cpu_rdata = rx_buf;
            default: cpu_rdata = '1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            count        <= '0;
            spie         <= 1'b0;
            spe          <= 1'b0;
            mstr         <= 1'b0;
            cpol         <= 1'b0;
            cpha         <= 1'b0;
            spr          <= '0;
            spif         <= 1'b0;
            wcol         <= 1'b0;
            modf         <= 1'b0;
            arm_flag_clr <= 1'b0;
            arm_modf_clr <= 1'b0;
            rx_buf       <= '1;
            tx_latch     <= '1;
            strobe_q     <= 1'b0;
            spi_mosi     <= '1;
            irq          <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            irq      <= spie && (spif || modf);

            if (wr_spcr) begin
                spie <= cpu_wdata[7];
                spe  <= cpu_wdata[6];
                mstr <= cpu_wdata[4];
                cpol <= cpu_wdata[3];
                cpha <= cpu_wdata[2];
                spr  <= cpu_wdata[1:0];
                if (arm_modf_clr) begin
                    modf         <= 1'b0;
                    arm_modf_clr <= 1'b0;
                end
            end

            if (rd_spsr && (spif || wcol)) begin
                arm_flag_clr <= 1'b1;
            end
            if (rd_spsr && modf) begin
                arm_modf_clr <= 1'b1;
            end

            if ((rd_spdr || wr_spdr) && arm_flag_clr) begin
                spif         <= 1'b0;
                wcol         <= 1'b0;
                arm_flag_clr <= 1'b0;
            end

            // Flag sets below are placed after the clear so they win.
            unique case (state)
                IDLE: begin
                    if (wr_spdr) begin
                        tx_latch <= cpu_wdata;
                        if (spe && mstr && !fault) begin
                            count <= load_value;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (wr_spdr) begin
                        wcol <= 1'b1;
                    end
                    if (fault || (wr_spcr && !cpu_wdata[6])) begin
                        state <= IDLE;
                    end else if (count == '0) begin
                        state    <= DONE;
                        strobe_q <= 1'b1;
                        spi_mosi <= tx_latch;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                DONE: begin
                    if (wr_spdr) begin
                        wcol <= 1'b1;
                    end
                    state <= IDLE;
                    if (!fault) begin
                        rx_buf <= spi_miso;
                        spif   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Last assignment: the fault overrides any SPCR write this cycle.
            if (fault) begin
                modf <= 1'b1;
                spe  <= 1'b0;
                mstr <= 1'b0;
            end
        end
    end

endmodule
